// File: rtl/sw_job_scheduler.sv
// Job scheduler for the Smith-Waterman engine: queues parameter jobs, launches runs, returns tagged best-score records.
// Optional run watchdog is compiled in with `define SW_SCHED_WATCHDOG_EN.
`ifndef MATCH_BIT
`define MATCH_BIT 8
`endif
`ifndef CALC_BIT
`define CALC_BIT 16
`endif
`ifndef MAX_T_NUM_BIT
`define MAX_T_NUM_BIT 8
`endif

module sw_job_scheduler #(
  parameter int unsigned JOB_DEPTH   = 4,
  parameter int unsigned TAG_BIT     = 4,
  parameter int unsigned MATCH_BIT   = `MATCH_BIT,
  parameter int unsigned CALC_BIT    = `CALC_BIT,
  parameter int unsigned IDX_BIT     = `MAX_T_NUM_BIT,
  parameter int unsigned ARM_LIMIT   = 3,
  parameter int unsigned TIMEOUT_BIT = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 job_valid_i,
  output logic                 job_ready_o,
  input  logic [MATCH_BIT-1:0] job_match_i,
  input  logic [MATCH_BIT-1:0] job_mismatch_i,
  input  logic [MATCH_BIT-1:0] job_alpha_i,
  input  logic [MATCH_BIT-1:0] job_beta_i,
  input  logic [TAG_BIT-1:0]   job_tag_i,
  output logic                 sw_start_o,
  output logic [MATCH_BIT-1:0] sw_match_o,
  output logic [MATCH_BIT-1:0] sw_mismatch_o,
  output logic [MATCH_BIT-1:0] sw_alpha_o,
  output logic [MATCH_BIT-1:0] sw_beta_o,
  input  logic                 sw_busy_i,
  input  logic                 sw_valid_i,
  input  logic [CALC_BIT-1:0]  sw_max_result_i,
  input  logic [IDX_BIT-1:0]   sw_match_idx_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [TAG_BIT-1:0]   res_tag_o,
  output logic [CALC_BIT-1:0]  res_max_o,
  output logic [IDX_BIT-1:0]   res_idx_o,
  output logic                 res_noarm_o,
  output logic                 res_timeout_o,
  output logic                 idle_o,
  output logic [15:0]          jobs_done_o
);

  localparam int unsigned PTR_W = (JOB_DEPTH > 1) ? $clog2(JOB_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ARM_W = (ARM_LIMIT > 1) ? $clog2(ARM_LIMIT) : 1;
  localparam int unsigned ENT_W = 4 * MATCH_BIT + TAG_BIT;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_ARM, S_RUN, S_REPORT, S_WAIT_IDLE
  } state_e;

  state_e state_q, state_d;

  logic [ENT_W-1:0] fifo_mem [JOB_DEPTH];
  logic [ENT_W-1:0] head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  logic [MATCH_BIT-1:0] match_q, match_d, mismatch_q, mismatch_d;
  logic [MATCH_BIT-1:0] alpha_q, alpha_d, beta_q, beta_d;
  logic [TAG_BIT-1:0]   tag_q, tag_d;
  logic [CALC_BIT-1:0]  best_q, best_d;
  logic [IDX_BIT-1:0]   best_idx_q, best_idx_d;
  logic                 start_q, start_d, valid_q, valid_d;
  logic                 noarm_q, noarm_d, timeout_q, timeout_d;
  logic [ARM_W-1:0]     arm_q, arm_d;
  logic [15:0]          done_q, done_d;
  logic                 arm_expired, wd_expired;

  assign job_ready_o = (count_q != CNT_W'(JOB_DEPTH));
  assign push        = job_valid_i && job_ready_o;
  assign pop         = (state_q == S_IDLE) && (count_q != '0);
  assign head        = fifo_mem[rd_ptr_q];
  assign arm_expired = (arm_q == ARM_W'(ARM_LIMIT - 1));

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {job_match_i, job_mismatch_i, job_alpha_i, job_beta_i, job_tag_i};
    end
  end

`ifdef SW_SCHED_WATCHDOG_EN
  logic [TIMEOUT_BIT-1:0] wd_q, wd_d;

  // Held at zero while arming, so the first RUN cycle starts the count from zero.
  always_comb begin
    wd_d = wd_q;
    if (state_q == S_ARM) begin
      wd_d = '0;
    end else if (state_q == S_RUN) begin
      wd_d = wd_q + 1'b1;
    end
  end

  assign wd_expired = (state_q == S_RUN) && (wd_d == '1);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_BIT != 0);
  assign wd_expired         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (pop) state_d = S_LAUNCH;
      S_LAUNCH:    state_d = S_ARM;
      S_ARM: begin
        if (sw_busy_i) begin
          state_d = S_RUN;
        end else if (arm_expired) begin
          state_d = S_REPORT;
        end
      end
      S_RUN:       if (!sw_busy_i || wd_expired) state_d = S_REPORT;
      S_REPORT:    if (res_ready_i) state_d = timeout_q ? S_WAIT_IDLE : S_IDLE;
      S_WAIT_IDLE: if (!sw_busy_i) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    match_d    = match_q;
    mismatch_d = mismatch_q;
    alpha_d    = alpha_q;
    beta_d     = beta_q;
    tag_d      = tag_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    noarm_d    = noarm_q;
    timeout_d  = timeout_q;
    arm_d      = arm_q;
    done_d     = done_q;
    start_d    = (state_d == S_LAUNCH);
    valid_d    = (state_d == S_REPORT);

    if (pop) begin
      {match_d, mismatch_d, alpha_d, beta_d, tag_d} = head;
      best_d     = '0;
      best_idx_d = '0;
      noarm_d    = 1'b0;
      timeout_d  = 1'b0;
    end

    if (state_q == S_LAUNCH) begin
      arm_d = '0;
    end else if (state_q == S_ARM) begin
      arm_d = arm_q + 1'b1;
    end

    // Strict compare: a tie keeps the earlier index.
    if ((state_q == S_ARM || state_q == S_RUN) && sw_valid_i && (sw_max_result_i > best_q)) begin
      best_d     = sw_max_result_i;
      best_idx_d = sw_match_idx_i;
    end

    if (state_q == S_ARM && state_d == S_REPORT) begin
      noarm_d = 1'b1;
    end
    if (state_q == S_RUN && sw_busy_i && wd_expired) begin
      timeout_d = 1'b1;
    end
    if (state_q == S_REPORT && res_ready_i) begin
      done_d = done_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      match_q    <= '0;
      mismatch_q <= '0;
      alpha_q    <= '0;
      beta_q     <= '0;
      tag_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      start_q    <= 1'b0;
      valid_q    <= 1'b0;
      noarm_q    <= 1'b0;
      timeout_q  <= 1'b0;
      arm_q      <= '0;
      done_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      alpha_q    <= alpha_d;
      beta_q     <= beta_d;
      tag_q      <= tag_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      start_q    <= start_d;
      valid_q    <= valid_d;
      noarm_q    <= noarm_d;
      timeout_q  <= timeout_d;
      arm_q      <= arm_d;
      done_q     <= done_d;
    end
  end

  assign sw_start_o    = start_q;
  assign sw_match_o    = match_q;
  assign sw_mismatch_o = mismatch_q;
  assign sw_alpha_o    = alpha_q;
  assign sw_beta_o     = beta_q;
  assign res_valid_o   = valid_q;
  assign res_tag_o     = tag_q;
  assign res_max_o     = best_q;
  assign res_idx_o     = best_idx_q;
  assign res_noarm_o   = noarm_q;
  assign res_timeout_o = timeout_q;
  assign jobs_done_o   = done_q;
  assign idle_o        = (state_q == S_IDLE) && (count_q == '0);

endmodule

// File: tb/tb_sw_job_scheduler.sv
// Directed bench for sw_job_scheduler: job vector table plus FIFO-fill, backpressure, watchdog and reset sequences.
module tb_sw_job_scheduler;

  localparam int MB = 8;
  localparam int CB = 16;
  localparam int IB = 8;
  localparam int TB = 4;
`ifdef SW_SCHED_WATCHDOG_EN
  localparam int TO_BIT = 4;
`else
  localparam int TO_BIT = 20;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          job_valid_i = 1'b0;
  logic          job_ready_o;
  logic [MB-1:0] job_match_i = '0, job_mismatch_i = '0, job_alpha_i = '0, job_beta_i = '0;
  logic [TB-1:0] job_tag_i = '0;
  logic          sw_start_o;
  logic [MB-1:0] sw_match_o, sw_mismatch_o, sw_alpha_o, sw_beta_o;
  logic          sw_busy_i = 1'b0;
  logic          sw_valid_i = 1'b0;
  logic [CB-1:0] sw_max_result_i = '0;
  logic [IB-1:0] sw_match_idx_i = '0;
  logic          res_valid_o;
  logic          res_ready_i = 1'b0;
  logic [TB-1:0] res_tag_o;
  logic [CB-1:0] res_max_o;
  logic [IB-1:0] res_idx_o;
  logic          res_noarm_o, res_timeout_o, idle_o;
  logic [15:0]   jobs_done_o;

  always #5 clk = ~clk;

  sw_job_scheduler #(
    .JOB_DEPTH(4), .TAG_BIT(TB), .MATCH_BIT(MB), .CALC_BIT(CB),
    .IDX_BIT(IB), .ARM_LIMIT(3), .TIMEOUT_BIT(TO_BIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_match_i(job_match_i), .job_mismatch_i(job_mismatch_i),
    .job_alpha_i(job_alpha_i), .job_beta_i(job_beta_i), .job_tag_i(job_tag_i),
    .sw_start_o(sw_start_o), .sw_match_o(sw_match_o), .sw_mismatch_o(sw_mismatch_o),
    .sw_alpha_o(sw_alpha_o), .sw_beta_o(sw_beta_o),
    .sw_busy_i(sw_busy_i), .sw_valid_i(sw_valid_i),
    .sw_max_result_i(sw_max_result_i), .sw_match_idx_i(sw_match_idx_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_tag_o(res_tag_o), .res_max_o(res_max_o), .res_idx_o(res_idx_o),
    .res_noarm_o(res_noarm_o), .res_timeout_o(res_timeout_o),
    .idle_o(idle_o), .jobs_done_o(jobs_done_o)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [15:0] exp_done = '0;

  // Engine model settings; mx/ix element k is sent on the k-th busy cycle.
  int                  eng_len = 0;
  logic [3:0][CB-1:0]  eng_mx = '0;
  logic [3:0][IB-1:0]  eng_ix = '0;
  logic                eng_tail_v = 1'b0;
  logic [CB-1:0]       eng_tail_mx = '0;
  logic [IB-1:0]       eng_tail_ix = '0;

  typedef struct {
    logic [MB-1:0]      m, mm, a, b;
    logic [TB-1:0]      tag;
    int                 len;
    logic [3:0][CB-1:0] mx;
    logic [3:0][IB-1:0] ix;
    logic               tail_v;
    logic [CB-1:0]      tail_mx;
    logic [IB-1:0]      tail_ix;
    logic [CB-1:0]      exp_max;
    logic [IB-1:0]      exp_idx;
    logic               exp_noarm;
    int                 exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin : engine_model
    int                 len;
    logic [3:0][CB-1:0] mx;
    logic [3:0][IB-1:0] ix;
    logic               tv;
    logic [CB-1:0]      tm;
    logic [IB-1:0]      ti;
    forever begin
      @(negedge clk);
      if (sw_start_o && eng_len > 0) begin
        len = eng_len; mx = eng_mx; ix = eng_ix;
        tv = eng_tail_v; tm = eng_tail_mx; ti = eng_tail_ix;
        @(negedge clk);
        sw_busy_i = 1'b1;
        for (int k = 0; k < len; k++) begin
          if (k < 4) begin
            sw_valid_i = 1'b1; sw_max_result_i = mx[k]; sw_match_idx_i = ix[k];
          end else begin
            sw_valid_i = 1'b0;
          end
          @(negedge clk);
        end
        sw_busy_i = 1'b0;
        sw_valid_i = tv; sw_max_result_i = tm; sw_match_idx_i = ti;
        @(negedge clk);
        sw_valid_i = 1'b0;
      end
    end
  end

  initial begin : time_limit
    #300000;
    $display("FAIL global_time_limit: got no finish, required finish before limit");
    $fatal(1, "time limit reached");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
  endtask

  task automatic push_job(input logic [MB-1:0] m, input logic [MB-1:0] mm,
                          input logic [MB-1:0] a, input logic [MB-1:0] b,
                          input logic [TB-1:0] t);
    int w = 0;
    while (!job_ready_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("push_ready_wait", 64'd0, 64'd1);
    job_match_i = m; job_mismatch_i = mm; job_alpha_i = a; job_beta_i = b;
    job_tag_i = t; job_valid_i = 1'b1;
    @(negedge clk);
    job_valid_i = 1'b0;
  endtask

  task automatic wait_res(output int cyc, output int starts);
    cyc = 0; starts = 0;
    while (!res_valid_o && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (sw_start_o) starts++;
    end
    if (!res_valid_o) chk("res_valid_wait", 64'd0, 64'd1);
  endtask

  task automatic take_res();
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
    exp_done++;
    chk("jobs_done", jobs_done_o, exp_done);
    chk("valid_drop", res_valid_o, 0);
  endtask

  task automatic check_reset_state(input string pfx);
    chk({pfx, "_ready"}, job_ready_o, 1);
    chk({pfx, "_start"}, sw_start_o, 0);
    chk({pfx, "_params"}, {sw_match_o, sw_mismatch_o, sw_alpha_o, sw_beta_o}, 0);
    chk({pfx, "_valid"}, res_valid_o, 0);
    chk({pfx, "_record"}, {res_tag_o, res_max_o, res_idx_o, res_noarm_o, res_timeout_o}, 0);
    chk({pfx, "_idle"}, idle_o, 1);
    chk({pfx, "_done"}, jobs_done_o, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int n, c, st;
    eng_len = v.len; eng_mx = v.mx; eng_ix = v.ix;
    eng_tail_v = v.tail_v; eng_tail_mx = v.tail_mx; eng_tail_ix = v.tail_ix;
    push_job(v.m, v.mm, v.a, v.b, v.tag);
    n = 1;
    while (!sw_start_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("start_lat", n, 2);
    chk("sw_params", {sw_match_o, sw_mismatch_o, sw_alpha_o, sw_beta_o}, {v.m, v.mm, v.a, v.b});
    wait_res(c, st);
    chk("res_lat", n + c, v.exp_lat);
    chk("extra_start", st, 0);
    chk("res_tag", res_tag_o, v.tag);
    chk("res_max", res_max_o, v.exp_max);
    chk("res_idx", res_idx_o, v.exp_idx);
    chk("res_noarm", res_noarm_o, v.exp_noarm);
    chk("res_timeout", res_timeout_o, 0);
    take_res();
  endtask

  initial begin : main
    int c, st, nst, bad_rec, bad_done;
    // mx/ix literals are listed element 3 down to element 0
    vecs[0] = '{8'd2, 8'd1, 8'd2, 8'd1, 4'd5, 10,
                {16'd4, 16'd7, 16'd7, 16'd3}, {8'd4, 8'd3, 8'd2, 8'd1},
                1'b0, 16'd0, 8'd0, 16'd7, 8'd2, 1'b0, 14};
    vecs[1] = '{8'd3, 8'd4, 8'd10, 8'd2, 4'd3, 6,
                {16'd40, 16'd30, 16'd20, 16'd10}, {8'd6, 8'd7, 8'd8, 8'd9},
                1'b0, 16'd0, 8'd0, 16'd40, 8'd6, 1'b0, 10};
    vecs[2] = '{8'hFF, 8'h80, 8'h01, 8'h7F, 4'hA, 5,
                {16'd5, 16'd5, 16'd5, 16'd5}, {8'd4, 8'd3, 8'd2, 8'd1},
                1'b1, 16'd100, 8'd77, 16'd100, 8'd77, 1'b0, 9};
    vecs[3] = '{8'd1, 8'd1, 8'd1, 8'd1, 4'hF, 4,
                {16'd0, 16'd0, 16'd0, 16'd0}, {8'd4, 8'd3, 8'd2, 8'd1},
                1'b0, 16'd0, 8'd0, 16'd0, 8'd0, 1'b0, 8};
    vecs[4] = '{8'd9, 8'd3, 8'd5, 8'd2, 4'd1, 0,
                {16'd0, 16'd0, 16'd0, 16'd0}, {8'd0, 8'd0, 8'd0, 8'd0},
                1'b0, 16'd0, 8'd0, 16'd0, 8'd0, 1'b1, 6};
    vecs[5] = '{8'h55, 8'hAA, 8'h0F, 8'hF0, 4'd2, 3,
                {16'd0, 16'hFFFF, 16'hFFFF, 16'd1}, {8'd0, 8'd6, 8'd5, 8'd1},
                1'b0, 16'd0, 8'd0, 16'hFFFF, 8'd5, 1'b0, 7};

    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("init");
    rst_n = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // FIFO fill while the engine runs the first job
    eng_len = 6; eng_tail_v = 1'b0;
    eng_mx = {16'd4, 16'd3, 16'd2, 16'd1};
    eng_ix = {8'd4, 8'd3, 8'd2, 8'd1};
    for (int i = 0; i < 5; i++) push_job(8'd1, 8'd1, 8'd1, 8'd1, TB'(i));
    chk("fifo_full_ready", job_ready_o, 0);
    chk("fifo_full_idle", idle_o, 0);
    for (int i = 0; i < 5; i++) begin
      wait_res(c, st);
      chk("fifo_tag", res_tag_o, i);
      chk("fifo_max", res_max_o, 4);
      take_res();
    end

    // Backpressure with a second job waiting in the FIFO
    eng_len = 5;
    eng_mx = {16'd9, 16'd2, 16'd9, 16'd3};
    eng_ix = {8'd4, 8'd3, 8'd2, 8'd1};
    push_job(8'd6, 8'd2, 8'd3, 8'd1, 4'd9);
    push_job(8'd6, 8'd2, 8'd3, 8'd1, 4'd10);
    wait_res(c, st);
    chk("bp_record", {res_tag_o, res_max_o, res_idx_o}, {4'd9, 16'd9, 8'd2});
    nst = 0; bad_rec = 0; bad_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(res_valid_o && res_tag_o == 4'd9 && res_max_o == 16'd9 && res_idx_o == 8'd2)) bad_rec++;
      if (sw_start_o) nst++;
      if (jobs_done_o !== exp_done) bad_done++;
    end
    chk("bp_record_stable", bad_rec, 0);
    chk("bp_no_start", nst, 0);
    chk("bp_done_hold", bad_done, 0);
    take_res();
    wait_res(c, st);
    chk("bp_next_tag", res_tag_o, 10);
    take_res();

`ifdef SW_SCHED_WATCHDOG_EN
    eng_len = 40;
    push_job(8'd4, 8'd4, 8'd4, 8'd4, 4'd6);
    wait_res(c, st);
    chk("wd_lat", c + 1, 19);
    chk("wd_timeout", res_timeout_o, 1);
    take_res();
    eng_len = 4;
    push_job(8'd5, 8'd5, 8'd5, 8'd5, 4'd7);
    c = 0;
    while (!sw_start_o && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("wd_restart_seen", sw_start_o, 1);
    chk("wd_restart_busy_low", sw_busy_i, 0);
    wait_res(c, st);
    chk("wd_next_tag", {res_tag_o, res_timeout_o}, {4'd7, 1'b0});
    take_res();
`endif

    // Reset in RUN with two jobs still queued
    eng_len = 30;
    eng_mx = {16'd1000, 16'd900, 16'd800, 16'd700};
    eng_ix = {8'd4, 8'd3, 8'd2, 8'd1};
    push_job(8'd7, 8'd7, 8'd7, 8'd7, 4'd1);
    push_job(8'd7, 8'd7, 8'd7, 8'd7, 4'd2);
    push_job(8'd7, 8'd7, 8'd7, 8'd7, 4'd3);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    exp_done = '0;
    check_reset_state("midrun_rst");
    nst = 0; bad_rec = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid_o) bad_rec++;
      if (sw_start_o) nst++;
    end
    chk("rst_no_result", bad_rec, 0);
    chk("rst_no_start", nst, 0);
    chk("rst_idle_after", idle_o, 1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/sw_job_scheduler.md
# sw_job_scheduler

Job scheduler in front of the Smith-Waterman engine. It queues scoring-parameter job descriptors from the host and launches one engine run per job. Each run gets a single-cycle start pulse and parameters held stable for the whole run. The block tracks the engine's busy signal, captures the best score and match index from the engine's result stream, and returns a tagged result record over a valid/ready handshake.

## Interface
Parameters:
- JOB_DEPTH, 4, job FIFO entries; power of two, ≥2
- TAG_BIT, 4, job tag width
- MATCH_BIT, `MATCH_BIT, scoring parameter width
- CALC_BIT, `CALC_BIT, score width
- IDX_BIT, `MAX_T_NUM_BIT, match index width
- ARM_LIMIT, 3, cycles to wait for engine busy after start
- TIMEOUT_BIT, 20, watchdog counter width (see Configuration)

Ports (name, direction, width, meaning):
- clk, in, 1, single clock, all logic on rising edge.
- rst_n, in, 1, reset: synchronous, active-high. The name is kept for codebase consistency.
- job_valid_i, in, 1, job descriptor offered.
- job_ready_o, out, 1, FIFO not full.
- job_match_i / job_mismatch_i / job_alpha_i / job_beta_i, in, MATCH_BIT each, unsigned magnitudes as the engine expects.
- job_tag_i, in, TAG_BIT, returned with the result.
- sw_start_o, out, 1, engine start pulse.
- sw_match_o / sw_mismatch_o / sw_alpha_o / sw_beta_o, out, MATCH_BIT each, engine parameters.
- sw_busy_i, in, 1, engine busy.
- sw_valid_i, in, 1, engine result-stream valid.
- sw_max_result_i, in, CALC_BIT, engine running max.
- sw_match_idx_i, in, IDX_BIT, engine match index.
- res_valid_o, out, 1; res_ready_i, in, 1, result handshake.
- res_tag_o (TAG_BIT), res_max_o (CALC_BIT), res_idx_o (IDX_BIT), res_noarm_o (1), res_timeout_o (1), out, result record.
- idle_o, out, 1, FSM in IDLE and FIFO empty.
- jobs_done_o, out, 16, completed-job count; wraps at 2^16.

## Operation
- Job FIFO: push on job_valid_i & job_ready_o. job_ready_o = (count != JOB_DEPTH), combinational from the registered count. Pointers wrap modulo JOB_DEPTH. A push and a pop in the same cycle leave count unchanged.
- FSM states and transitions:
  - IDLE: count>0 → pop; load sw_*_o from the head entry; latch the tag; clear the best registers. Go to LAUNCH.
  - LAUNCH: sw_start_o=1 for this one cycle → ARM.
  - ARM: sw_busy_i=1 → RUN. If ARM_LIMIT cycles pass with no busy → REPORT with res_noarm_o=1.
  - RUN: sw_busy_i=0 → REPORT. Watchdog expiry → REPORT with res_timeout_o=1 (only when the watchdog is compiled in).
  - REPORT: res_valid_o=1 and the record is held stable. On res_ready_i → increment jobs_done_o; go to IDLE, or to WAIT_IDLE if res_timeout_o=1.
  - WAIT_IDLE: sw_busy_i=0 → IDLE.
- Best capture, in ARM and RUN: when sw_valid_i is high and sw_max_result_i > best (unsigned, strict), update best and best_idx. Ties keep the earlier index.
- sw_*_o change only on a pop. Parameters are therefore stable from the start pulse to the end of the run, covering the engine's registered parameter sampling.

## Timing
- Reset values: job_ready_o=1, sw_start_o=0, sw_*_o=0, res_valid_o=0, res_tag_o=0, res_max_o=0, res_idx_o=0, res_noarm_o=0, res_timeout_o=0, idle_o=1, jobs_done_o=0. The FIFO is emptied and the FSM goes to IDLE.
- A job accepted in cycle N into an empty FIFO with the FSM in IDLE:
  - pop in N+1;
  - sw_start_o high in N+2;
  - earliest ARM exit in N+4, because the engine raises busy one cycle after start.
- busy falling in cycle M gives res_valid_o high in M+1. A sw_valid_i seen in cycle M itself is still captured.
- res_ready_i high on the first valid cycle frees the scheduler: the next pop happens in the following IDLE cycle. Back-to-back jobs therefore have at least 4 cycles between start pulses.
- All outputs are registered except job_ready_o and idle_o.
- Reset asserted mid-run takes effect at the next clock edge: the FSM returns to IDLE, the FIFO is emptied, and no result is emitted. The engine is not reset by this block.

## Configuration
- SW_SCHED_WATCHDOG_EN defined:
  - A TIMEOUT_BIT counter clears on entry to RUN and increments every RUN cycle.
  - When it reaches all-ones, the FSM goes to REPORT with res_timeout_o=1, then to WAIT_IDLE.
- Undefined: no counter is built, RUN waits indefinitely, res_timeout_o is tied 0, and WAIT_IDLE is unreachable.

## Test plan
- Single job (match=2, mismatch=1, alpha=2, beta=1, tag=5). The engine model is busy for 10 cycles and sends maxima 3, 7, 7, 4 at indices 1, 2, 3, 4. Required: one start pulse; the result record is tag=5, max=7, idx=2; jobs_done_o=1.
- Fill the FIFO: 5 pushes at JOB_DEPTH=4 while the engine is busy. Required: job_ready_o low after the 4th accept (or after the 5th if a pop occurred); results come out in tag order 0..4.
- Backpressure: hold res_ready_i low for 20 cycles. Required: the record stays stable, no new start pulse is issued, and jobs_done_o is unchanged until the handshake.
- No-arm: the engine never raises busy. Required: REPORT 3 cycles after ARM entry with res_noarm_o=1, max=0.
- Watchdog, with SW_SCHED_WATCHDOG_EN and TIMEOUT_BIT=4: the engine stays busy for 40 cycles. Required: res_timeout_o=1 after 15 RUN cycles, and the next start pulse comes only after busy falls.
- Reset asserted in RUN with 2 jobs queued. Required: next cycle all outputs are at their reset values, idle_o=1, and no result is emitted.
